// File: rtl/shared_pkg.sv
// Shared FIFO constants and the read/write outcome type.
package shared_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_OK,
    OP_REJECT
  } op_result_e;

endpackage

// File: rtl/fifo_if.sv
// Bundle of FIFO signals, including flush, thresholds, read-valid and occupancy.
interface FIFO_interface
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input logic clk
);

  logic                  rst_n;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic                  flush;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport DUT (
    input  clk, rst_n, data_in, wr_en, rd_en, flush, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count
  );

  modport TEST (
    input  clk, data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count,
    output rst_n, data_in, wr_en, rd_en, flush, af_thresh, ae_thresh
  );

  modport MONITOR (
    input clk, rst_n, data_in, wr_en, rd_en, flush, af_thresh, ae_thresh,
          data_out, rd_valid, wr_ack, overflow, underflow, full, empty,
          almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_mem.sv
// Register array with one write port and one registered read port.
module fifo_mem #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [PTR_W-1:0]      waddr,
  input  logic [FIFO_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [PTR_W-1:0]      raddr,
  output logic [FIFO_WIDTH-1:0] rdata
);

  logic [FIFO_WIDTH-1:0] mem [0:FIFO_DEPTH-1];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/empty thresholds, flush and read-valid.
module sync_fifo_prog
  import shared_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(FIFO_DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] af_eff;
  logic [CNT_W-1:0] ae_eff;
  logic             wr_ok;
  logic             rd_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;
  assign count_next  = count + CNT_W'(wr_ok) - CNT_W'(rd_ok);

  assign af_eff      = (af_thresh > DEPTH_C) ? DEPTH_C : af_thresh;
  assign ae_eff      = (ae_thresh > DEPTH_C) ? DEPTH_C : ae_thresh;
  assign almostfull  = (count >= af_eff);
  assign almostempty = (count <= ae_eff);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_next;
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      rd_valid  <= rd_ok;
    end
  end

  fifo_mem #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PTR_W     (PTR_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_ok && rst_n && !flush),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (rd_ok && !flush),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog at depth 8 and depth 5 against a queue-based reference model.
module tb_sync_fifo_prog;
  import shared_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  FIFO_interface #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) if8 (.clk(clk));
  FIFO_interface #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) if5 (.clk(clk));

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut8 (
    .clk(clk), .rst_n(if8.rst_n), .data_in(if8.data_in), .wr_en(if8.wr_en),
    .rd_en(if8.rd_en), .flush(if8.flush), .af_thresh(if8.af_thresh),
    .ae_thresh(if8.ae_thresh), .data_out(if8.data_out), .rd_valid(if8.rd_valid),
    .wr_ack(if8.wr_ack), .overflow(if8.overflow), .underflow(if8.underflow),
    .full(if8.full), .empty(if8.empty), .almostfull(if8.almostfull),
    .almostempty(if8.almostempty), .count(if8.count)
  );

  sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) dut5 (
    .clk(clk), .rst_n(if5.rst_n), .data_in(if5.data_in), .wr_en(if5.wr_en),
    .rd_en(if5.rd_en), .flush(if5.flush), .af_thresh(if5.af_thresh),
    .ae_thresh(if5.ae_thresh), .data_out(if5.data_out), .rd_valid(if5.rd_valid),
    .wr_ack(if5.wr_ack), .overflow(if5.overflow), .underflow(if5.underflow),
    .full(if5.full), .empty(if5.empty), .almostfull(if5.almostfull),
    .almostempty(if5.almostempty), .count(if5.count)
  );

  int          passed = 0;
  int          total  = 0;
  bit          sel    = 1'b0;
  int          depth  = 8;
  string       phase  = "init";
  logic [3:0]  aft    = 4'd6;
  logic [3:0]  aet    = 4'd2;

  logic [15:0] mq[$];
  logic [15:0] exp_dout = '0;
  bit          exp_rv   = 1'b0;
  op_result_e  wr_op    = OP_NONE;
  op_result_e  rd_op    = OP_NONE;

  logic [31:0] o_count, o_full, o_empty, o_af, o_ae;
  logic [31:0] o_wack, o_ovf, o_udf, o_rv, o_dout;

  always_comb begin
    o_count = 32'(if8.count);
    o_full  = 32'(if8.full);
    o_empty = 32'(if8.empty);
    o_af    = 32'(if8.almostfull);
    o_ae    = 32'(if8.almostempty);
    o_wack  = 32'(if8.wr_ack);
    o_ovf   = 32'(if8.overflow);
    o_udf   = 32'(if8.underflow);
    o_rv    = 32'(if8.rd_valid);
    o_dout  = 32'(if8.data_out);
    if (sel) begin
      o_count = 32'(if5.count);
      o_full  = 32'(if5.full);
      o_empty = 32'(if5.empty);
      o_af    = 32'(if5.almostfull);
      o_ae    = 32'(if5.almostempty);
      o_wack  = 32'(if5.wr_ack);
      o_ovf   = 32'(if5.overflow);
      o_udf   = 32'(if5.underflow);
      o_rv    = 32'(if5.rd_valid);
      o_dout  = 32'(if5.data_out);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s/%s @%0t: observed %0h expected %0h", phase, tag, $time, obs, exp);
  endtask

  task automatic check_all();
    int thr_af, thr_ae, sz;
    sz     = mq.size();
    thr_af = sel ? int'(aft[2:0]) : int'(aft);
    thr_ae = sel ? int'(aet[2:0]) : int'(aet);
    if (thr_af > depth) thr_af = depth;
    if (thr_ae > depth) thr_ae = depth;
    check("count",       o_count, 32'(sz));
    check("full",        o_full,  32'(sz == depth));
    check("empty",       o_empty, 32'(sz == 0));
    check("almostfull",  o_af,    32'(sz >= thr_af));
    check("almostempty", o_ae,    32'(sz <= thr_ae));
    check("wr_ack",      o_wack,  32'(wr_op == OP_OK));
    check("overflow",    o_ovf,   32'(wr_op == OP_REJECT));
    check("underflow",   o_udf,   32'(rd_op == OP_REJECT));
    check("rd_valid",    o_rv,    32'(exp_rv));
    check("data_out",    o_dout,  32'(exp_dout));
  endtask

  // One clock: drive at negedge, advance the model, check after the edge.
  task automatic cyc(input bit rn, input bit fl, input bit w, input bit r, input logic [15:0] d);
    int sz;
    @(negedge clk);
    if8.rst_n = rn;  if8.flush = fl;  if8.wr_en = w;  if8.rd_en = r;  if8.data_in = d;
    if8.af_thresh = aft;  if8.ae_thresh = aet;
    if5.rst_n = rn;  if5.flush = fl;  if5.wr_en = w;  if5.rd_en = r;  if5.data_in = d;
    if5.af_thresh = aft[2:0];  if5.ae_thresh = aet[2:0];
    wr_op  = OP_NONE;
    rd_op  = OP_NONE;
    exp_rv = 1'b0;
    if (!rn) begin
      mq.delete();
      exp_dout = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      sz = mq.size();
      if (r) begin
        if (sz > 0) begin
          exp_dout = mq.pop_front();
          rd_op    = OP_OK;
          exp_rv   = 1'b1;
        end else rd_op = OP_REJECT;
      end
      if (w) begin
        if (sz < depth) begin
          mq.push_back(d);
          wr_op = OP_OK;
        end else wr_op = OP_REJECT;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr(input logic [15:0] d); cyc(1'b1, 1'b0, 1'b1, 1'b0, d); endtask
  task automatic rd();                     cyc(1'b1, 1'b0, 1'b0, 1'b1, 16'h0); endtask
  task automatic idle();                   cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0); endtask

  task automatic random_run(input int n, input int thr_max);
    int wp, rp;
    wp = 50;
    rp = 50;
    for (int i = 0; i < n; i++) begin
      if (i % 24 == 0) begin
        wp  = $urandom_range(10, 90);
        rp  = 100 - wp;
        aft = 4'($urandom_range(0, thr_max));
        aet = 4'($urandom_range(0, thr_max));
      end
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
          16'($urandom));
    end
  endtask

  initial begin
    phase = "reset";
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'hdead);

    phase = "fill";
    for (int i = 1; i <= 8; i++) wr(16'(i));
    wr(16'h0009);

    phase = "drain";
    for (int i = 0; i < 9; i++) rd();

    phase = "thresh";
    for (int i = 1; i <= 6; i++) wr(16'(16'h0100 + i));
    aft = 4'd7;
    idle();
    aft = 4'd12;
    idle();
    wr(16'h0107);
    wr(16'h0108);

    phase = "simul_full";
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'hbeef);
    for (int i = 0; i < 7; i++) rd();
    phase = "simul_empty";
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0a0a);

    phase = "flush";
    for (int i = 0; i < 4; i++) wr(16'(16'h0200 + i));
    rd();
    wr(16'h0204);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0f0f);
    idle();

    phase = "reset_mid";
    for (int i = 0; i < 3; i++) wr(16'(16'h0300 + i));
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    idle();

    phase = "rand8";
    random_run(400, 15);

    phase = "wrap5";
    sel   = 1'b1;
    depth = 5;
    aft   = 4'd4;
    aet   = 4'd1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 1; i <= 3; i++) wr(16'(16'h0500 + i));
    for (int i = 0; i < 3; i++)  rd();
    for (int i = 4; i <= 7; i++) wr(16'(16'h0500 + i));
    for (int i = 0; i < 4; i++)  rd();
    rd();

    phase = "rand5";
    random_run(400, 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
